// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory read port and decode-side queue port.
// The master modport is the fetch unit; the slave modport is the memory/decode/branch side.
interface instruction_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        input  redirect_valid, redirect_target, mem_ack, mem_rdata, inst_ready,
        output mem_req, mem_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_target, mem_ack, mem_rdata, inst_ready,
        input  mem_req, mem_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, issues one sequential memory read at a time and
// queues fetched {pc, word} pairs in a 2-entry FIFO; a redirect flushes and restarts fetch.
module instruction_fetch #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] req_addr, req_addr_next;
    logic [ADDR_W-1:0] fifo_pc   [2];
    logic [DATA_W-1:0] fifo_data [2];
    logic              rd_ptr, wr_ptr;
    logic [1:0]        count, count_next;
    logic              push, pop;

    assign bus.mem_req    = (state != IDLE);
    assign bus.mem_addr   = req_addr;
    assign bus.inst_valid = (count != 2'd0);
    assign bus.inst_data  = fifo_data[rd_ptr];
    assign bus.inst_pc    = fifo_pc[rd_ptr];

    // A redirect kills the word acked in the same cycle; a pop in that cycle still counts as delivered.
    assign push       = (state == REQ) && bus.mem_ack && !bus.redirect_valid;
    assign pop        = (count != 2'd0) && bus.inst_ready;
    assign count_next = bus.redirect_valid ? 2'd0
                                           : count + 2'(push) - 2'(pop);

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        case (state)
            IDLE: begin
                if (count_next != 2'd2) begin
                    state_next = REQ;
                end
                if (bus.redirect_valid) begin
                    req_addr_next = bus.redirect_target;
                end
            end
            REQ: begin
                if (bus.redirect_valid) begin
                    // Without an ack the request must stay on the bus until memory answers it.
                    if (bus.mem_ack) begin
                        req_addr_next = bus.redirect_target;
                    end else begin
                        state_next = DISCARD;
                    end
                end else if (bus.mem_ack) begin
                    pc_next       = pc + PC_STEP;
                    req_addr_next = pc + PC_STEP;
                    state_next    = (count_next == 2'd2) ? IDLE : REQ;
                end
            end
            DISCARD: begin
                if (bus.mem_ack) begin
                    state_next    = REQ;
                    req_addr_next = bus.redirect_valid ? bus.redirect_target : pc;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (bus.redirect_valid) begin
            pc_next = bus.redirect_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
            count    <= count_next;
            if (bus.redirect_valid) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr]   <= req_addr;
                    fifo_data[wr_ptr] <= bus.mem_rdata;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: two DUTs (RESET_PC 0 and FFFE) behind simple
// memory models whose word is addr ^ A5A5 and whose ack waits a programmable number of cycles.
module tb_instruction_fetch;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] delay0 = 4'd0;
    logic [3:0] wcnt0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    instruction_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
    instruction_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

    instruction_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(16'h0000)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0.master)
    );

    instruction_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(16'hFFFE)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1.master)
    );

    // Memory for dut0: acks once the request has waited delay0 cycles; cleared by rst.
    always @(posedge clk) begin
        if (rst || bus0.mem_ack) begin
            wcnt0 <= 4'd0;
        end else if (bus0.mem_req) begin
            wcnt0 <= wcnt0 + 4'd1;
        end
    end
    assign bus0.mem_ack   = bus0.mem_req && (wcnt0 >= delay0);
    assign bus0.mem_rdata = bus0.mem_addr ^ 16'hA5A5;

    assign bus1.mem_ack         = bus1.mem_req;
    assign bus1.mem_rdata       = bus1.mem_addr ^ 16'hA5A5;
    assign bus1.redirect_valid  = 1'b0;
    assign bus1.redirect_target = 16'h0000;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [15:0] target);
        bus0.inst_ready      = ready;
        bus1.inst_ready      = ready;
        bus0.redirect_valid  = redir;
        bus0.redirect_target = target;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of cycle 0 (rst just dropped).
    task automatic resetDut(input logic [3:0] dly, input logic ready);
        rst    = 1'b1;
        delay0 = dly;
        applyStimulus(ready, 1'b0, 16'h0000);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] exp1Pc [4];
        logic        found;
        exp1Pc[0] = 16'hFFFE;
        exp1Pc[1] = 16'hFFFF;
        exp1Pc[2] = 16'h0000;
        exp1Pc[3] = 16'h0001;

        // Reset values, then zero-wait streaming on both DUTs.
        rst    = 1'b1;
        delay0 = 4'd0;
        applyStimulus(1'b1, 1'b0, 16'h0000);
        step();
        step();
        checkOutput("rst_mem_req", 16'(bus0.mem_req), 16'd0);
        checkOutput("rst_mem_addr", bus0.mem_addr, 16'h0000);
        checkOutput("rst_inst_valid", 16'(bus0.inst_valid), 16'd0);
        checkOutput("rst_inst_data", bus0.inst_data, 16'h0000);
        checkOutput("rst_inst_pc", bus0.inst_pc, 16'h0000);
        checkOutput("rst1_mem_addr", bus1.mem_addr, 16'hFFFE);
        checkOutput("rst1_mem_req", 16'(bus1.mem_req), 16'd0);
        rst = 1'b0;

        step();
        checkOutput("c1_mem_req", 16'(bus0.mem_req), 16'd1);
        checkOutput("c1_mem_addr", bus0.mem_addr, 16'h0000);
        checkOutput("c1_inst_valid", 16'(bus0.inst_valid), 16'd0);
        checkOutput("c1_dut1_valid", 16'(bus1.inst_valid), 16'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("stream_mem_addr", bus0.mem_addr, 16'(i + 1));
            checkOutput("stream_inst_valid", 16'(bus0.inst_valid), 16'd1);
            checkOutput("stream_inst_pc", bus0.inst_pc, 16'(i));
            checkOutput("stream_inst_data", bus0.inst_data, 16'(i) ^ 16'hA5A5);
            checkOutput("wrap_inst_pc", bus1.inst_pc, exp1Pc[i]);
            checkOutput("wrap_inst_data", bus1.inst_data, exp1Pc[i] ^ 16'hA5A5);
        end

        // Backpressure: ready low for cycles 0..5.
        resetDut(4'd0, 1'b0);
        step();
        checkOutput("bp_c1_addr", bus0.mem_addr, 16'h0000);
        step();
        checkOutput("bp_c2_addr", bus0.mem_addr, 16'h0001);
        checkOutput("bp_c2_req", 16'(bus0.mem_req), 16'd1);
        for (int i = 3; i <= 6; i++) begin
            step();
            checkOutput("bp_stall_req", 16'(bus0.mem_req), 16'd0);
            checkOutput("bp_stall_valid", 16'(bus0.inst_valid), 16'd1);
            checkOutput("bp_stall_pc", bus0.inst_pc, 16'h0000);
        end
        applyStimulus(1'b1, 1'b0, 16'h0000);
        step();
        checkOutput("bp_c7_pc", bus0.inst_pc, 16'h0001);
        checkOutput("bp_c7_req", 16'(bus0.mem_req), 16'd1);
        checkOutput("bp_c7_addr", bus0.mem_addr, 16'h0002);
        step();
        checkOutput("bp_c8_pc", bus0.inst_pc, 16'h0002);
        checkOutput("bp_c8_addr", bus0.mem_addr, 16'h0003);
        step();
        checkOutput("bp_c9_pc", bus0.inst_pc, 16'h0003);

        // Redirect in IDLE with a full queue and a pop in the same cycle.
        resetDut(4'd0, 1'b0);
        step();
        step();
        step();
        checkOutput("ri_idle_req", 16'(bus0.mem_req), 16'd0);
        applyStimulus(1'b1, 1'b1, 16'h0020);
        step();
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("ri_flush_valid", 16'(bus0.inst_valid), 16'd0);
        checkOutput("ri_target_addr", bus0.mem_addr, 16'h0020);
        checkOutput("ri_target_req", 16'(bus0.mem_req), 16'd1);
        step();
        checkOutput("ri_first_pc", bus0.inst_pc, 16'h0020);
        checkOutput("ri_first_data", bus0.inst_data, 16'hA585);

        // Redirect coincident with mem_ack and a pop.
        resetDut(4'd0, 1'b1);
        step();
        step();
        checkOutput("ra_pre_pc", bus0.inst_pc, 16'h0000);
        checkOutput("ra_pre_addr", bus0.mem_addr, 16'h0001);
        applyStimulus(1'b1, 1'b1, 16'h0080);
        step();
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("ra_flush_valid", 16'(bus0.inst_valid), 16'd0);
        checkOutput("ra_target_addr", bus0.mem_addr, 16'h0080);
        step();
        checkOutput("ra_first_valid", 16'(bus0.inst_valid), 16'd1);
        checkOutput("ra_first_pc", bus0.inst_pc, 16'h0080);
        checkOutput("ra_first_data", bus0.inst_data, 16'hA525);

        // Slow memory: redirect one cycle after the request for @5 goes out.
        resetDut(4'd3, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus0.mem_req && bus0.mem_addr == 16'h0005) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("rd_wait_req5", 16'(found), 16'd1);
        step();
        applyStimulus(1'b1, 1'b1, 16'h0040);
        step();
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("rd_hold_addr", bus0.mem_addr, 16'h0005);
        checkOutput("rd_hold_req", 16'(bus0.mem_req), 16'd1);
        checkOutput("rd_flush_valid", 16'(bus0.inst_valid), 16'd0);
        step();
        checkOutput("rd_ack_addr", bus0.mem_addr, 16'h0005);
        step();
        checkOutput("rd_target_addr", bus0.mem_addr, 16'h0040);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus0.inst_valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("rd_wait_valid", 16'(found), 16'd1);
        checkOutput("rd_first_pc", bus0.inst_pc, 16'h0040);
        checkOutput("rd_first_data", bus0.inst_data, 16'hA5E5);

        // Reset while a discarded request is outstanding.
        resetDut(4'd3, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus0.mem_req && bus0.mem_addr == 16'h0002) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("rr_wait_req2", 16'(found), 16'd1);
        applyStimulus(1'b1, 1'b1, 16'h0010);
        step();
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("rr_discard_addr", bus0.mem_addr, 16'h0002);
        checkOutput("rr_discard_req", 16'(bus0.mem_req), 16'd1);
        rst = 1'b1;
        step();
        checkOutput("rr_mem_req", 16'(bus0.mem_req), 16'd0);
        checkOutput("rr_mem_addr", bus0.mem_addr, 16'h0000);
        checkOutput("rr_inst_valid", 16'(bus0.inst_valid), 16'd0);
        checkOutput("rr_inst_data", bus0.inst_data, 16'h0000);
        checkOutput("rr_inst_pc", bus0.inst_pc, 16'h0000);
        rst = 1'b0;
        step();
        checkOutput("rr_restart_req", 16'(bus0.mem_req), 16'd1);
        checkOutput("rr_restart_addr", bus0.mem_addr, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus0.inst_valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("rr_wait_valid", 16'(found), 16'd1);
        checkOutput("rr_first_pc", bus0.inst_pc, 16'h0000);
        checkOutput("rr_first_data", bus0.inst_data, 16'hA5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
